draw_layer_arbiter: RTL and testbench
=====================================

Name: draw_layer_arbiter

Overview:
Per-pixel compositor and effects scheduler sitting between the draw units (frame borders, board blocks, preview/score digits, logo/help text) and the VGA RGB output. It arbitrates the four layers' RGB/dav pairs by fixed priority, gates layers by game_state, and blinks the text layer. It also sequences a frame-synchronous flash effect on the board layer when the game logic requests it (line clear). It is the single owner of the final 3-bit RGB driven to the VGA pins.

Parameters:
H_VISIBLE, 800, visible pixels per line; x >= H_VISIBLE is blanking
V_VISIBLE, 600, visible lines per frame; y >= V_VISIBLE is blanking
BG_RGB, 3'b000, colour when no enabled layer is valid
STATE_LOGO, 4'b0000, game_state value of the logo/instructions screen
LOGO_MASK, 4'b1101, layer enable mask in STATE_LOGO (bit i = layer i)
PLAY_MASK, 4'b0111, layer enable mask in every other state
BLINK_BIT, 5, frame_cnt bit that gates layer 3 (toggles every 32 frames)
FLASH_FRAMES, 4, frames per flash phase (on or off), >= 1
FLASH_CYCLES, 3, on/off pairs per flash request, >= 1

Ports:
vga_clk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
x  in  11  current pixel X
y  in  10  current pixel Y
game_state  in  4  current game state
layer_rgb  in  12  layer i colour on bits [3i+2:3i]; layer 0 = frames, 1 = board, 2 = preview/score, 3 = text
layer_dav  in  4  layer i pixel valid
flash_req  in  1  single-cycle pulse requesting a board flash
rgb_out  out  3  final pixel colour
pix_active  out  1  1 when an enabled layer supplied the pixel
flash_busy  out  1  1 from acceptance of flash_req until the flash sequence ends

Behaviour:
- Reset is synchronous and active-high on vga_clk, and dominates all other inputs. On reset: rgb_out=000, pix_active=0, flash_busy=0, frame_cnt=0, FSM=IDLE, phase and cycle counters=0.
- frame_start: a one-cycle internal pulse, registered, high on the cycle after x==0 && y==0 is sampled. frame_cnt (6 bit) increments on frame_start and wraps 63->0.
- Enable mask: en = (game_state==STATE_LOGO) ? LOGO_MASK : PLAY_MASK. game_state is sampled in the same cycle as the layer inputs. In addition, en[3] is forced to 0 when frame_cnt[BLINK_BIT]==1.
- Arbitration: the lowest index i with layer_dav[i] && en[i] wins. Priority is fixed 0 > 1 > 2 > 3.
- Output timing: rgb_out and pix_active are registered, with a latency of exactly 1 cycle from the x/y/layer inputs.
- Winner output: rgb_out = winner colour and pix_active = 1.
- No winner: rgb_out = BG_RGB and pix_active = 0.
- Blanking: if x >= H_VISIBLE or y >= V_VISIBLE, then rgb_out=000 and pix_active=0, regardless of layers or BG_RGB.
- Flash FSM states: IDLE, ARMED, ON, OFF.
  - IDLE: on flash_req, go to ARMED and set flash_busy=1 on the next cycle.
  - ARMED: on frame_start, go to ON with phase_cnt=0 and cyc_cnt=0.
  - ON: increment phase_cnt on each frame_start. When FLASH_FRAMES frame_starts have elapsed, go to OFF and clear phase_cnt.
  - OFF: same counting as ON. On completion, increment cyc_cnt. If cyc_cnt reaches FLASH_CYCLES, go to IDLE and clear flash_busy; otherwise go back to ON.
- Flash effect: in ON, a layer-1 pixel that wins arbitration is output as ~layer colour (bitwise invert). OFF is visually normal. Layers 0, 2 and 3 are unaffected.
- flash_req received while flash_busy=1 (ARMED/ON/OFF) is ignored; it is neither queued nor restarts the sequence.
- flash_req and rst in the same cycle: reset wins and the FSM stays in IDLE.
- Reset mid-flash: the FSM returns to IDLE and the effect stops on the next output pixel.
- A game_state change takes effect on the enable mask for the very next input pixel; it does not wait for the frame boundary.

Test Plan:
1. Reset, with x,y sweeping and all layer_dav=0 -> rgb_out=000 and pix_active=0 every cycle; after reset releases, visible pixels output BG_RGB.
2. game_state=0001, layer_dav=0111, colours L0=011, L1=100, L2=110 -> one cycle later rgb_out=011; then drop dav[0] -> rgb_out=100.
3. game_state=STATE_LOGO, only dav[1]=1 with L1=100 -> pix_active=0 and rgb_out=BG_RGB, since LOGO_MASK bit1=0.
4. game_state=STATE_LOGO, only dav[3]=1 with L3=111, over 64 frames -> 111 in frames 0-31 and BG_RGB in frames 32-63.
5. game_state=0001, flash_req pulse, L1=100 held valid -> flash_busy rises next cycle. Output is 011 for 4 frames, then 100 for 4 frames, repeated 3 times; flash_busy falls at the end of frame 24 after the first frame_start.
6. Second flash_req mid-flash -> sequence length unchanged. rst asserted during ON -> next pixel outputs 100 and flash_busy=0.

Source files
------------

// File: rtl/draw_layer_arbiter.sv
// Final-pixel compositor for the VGA path: fixed-priority layer arbitration,
// state-based layer gating, text blink and a frame-synchronous board flash.
module draw_layer_arbiter #(
    parameter int          H_VISIBLE    = 800,
    parameter int          V_VISIBLE    = 600,
    parameter logic [2:0]  BG_RGB       = 3'b000,
    parameter logic [3:0]  STATE_LOGO   = 4'b0000,
    parameter logic [3:0]  LOGO_MASK    = 4'b1101,
    parameter logic [3:0]  PLAY_MASK    = 4'b0111,
    parameter int          BLINK_BIT    = 5,
    parameter int          FLASH_FRAMES = 4,
    parameter int          FLASH_CYCLES = 3
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [3:0]  game_state,
    input  logic [11:0] layer_rgb,
    input  logic [3:0]  layer_dav,
    input  logic        flash_req,
    output logic [2:0]  rgb_out,
    output logic        pix_active,
    output logic        flash_busy
);

    localparam logic [10:0] H_LIM = 11'(H_VISIBLE);
    localparam logic [9:0]  V_LIM = 10'(V_VISIBLE);
    localparam int PH_W = $clog2(FLASH_FRAMES + 1);
    localparam int CY_W = $clog2(FLASH_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FLASH_FRAMES - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(FLASH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, ON, OFF} flash_state_t;

    flash_state_t    flash_state;
    logic [PH_W-1:0] phase_cnt;
    logic [CY_W-1:0] cyc_cnt;
    logic            frame_start;
    logic [5:0]      frame_cnt;
    logic [3:0]      en_p0;
    logic            vld_p0;
    logic [2:0]      rgb_p0;

    // Returns {valid, colour}; lowest-index enabled layer wins, board may be inverted.
    function automatic logic [3:0] select_pixel(input logic [11:0] rgb,
                                                input logic [3:0]  hit,
                                                input logic        invert_board);
        logic [3:0] res;
        res = {1'b0, BG_RGB};
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                res = {1'b1, (i == 1 && invert_board) ? ~rgb[3*i +: 3] : rgb[3*i +: 3]};
            end
        end
        return res;
    endfunction

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            frame_start <= 1'b0;
            frame_cnt   <= 6'd0;
        end else begin
            frame_start <= (x == 11'd0) && (y == 10'd0);
            if (frame_start) frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // Stage p0: enable mask, arbitration and blanking from the current inputs
    always_comb begin
        en_p0 = (game_state == STATE_LOGO) ? LOGO_MASK : PLAY_MASK;
        if (frame_cnt[BLINK_BIT]) en_p0[3] = 1'b0;
        if (x >= H_LIM || y >= V_LIM) begin
            {vld_p0, rgb_p0} = 4'b0000;
        end else begin
            {vld_p0, rgb_p0} = select_pixel(layer_rgb, layer_dav & en_p0,
                                            flash_state == ON);
        end
    end

    // Stage p1: registered pixel to the VGA pins
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rgb_out    <= 3'b000;
            pix_active <= 1'b0;
        end else begin
            rgb_out    <= rgb_p0;
            pix_active <= vld_p0;
        end
    end

    // Flash sequencer: every phase lasts FLASH_FRAMES frame_starts.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            flash_state <= IDLE;
            phase_cnt   <= '0;
            cyc_cnt     <= '0;
            flash_busy  <= 1'b0;
        end else begin
            case (flash_state)
                IDLE: begin
                    if (flash_req) begin
                        flash_state <= ARMED;
                        flash_busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (frame_start) begin
                        flash_state <= ON;
                        phase_cnt   <= '0;
                        cyc_cnt     <= '0;
                    end
                end
                ON: begin
                    if (frame_start) begin
                        if (phase_cnt == PH_LAST) begin
                            flash_state <= OFF;
                            phase_cnt   <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (frame_start) begin
                        if (phase_cnt == PH_LAST) begin
                            phase_cnt <= '0;
                            if (cyc_cnt == CY_LAST) begin
                                flash_state <= IDLE;
                                flash_busy  <= 1'b0;
                                cyc_cnt     <= '0;
                            end else begin
                                flash_state <= ON;
                                cyc_cnt     <= cyc_cnt + 1'b1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    flash_state <= IDLE;
                    flash_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Randomized bench for draw_layer_arbiter on a shrunken raster, checked every
// cycle against a frame-count based reference model.
module tb_draw_layer_arbiter;

    localparam int HV = 8, VV = 4, HT = 10, VT = 6;
    localparam int FRAME = HT * VT;
    localparam int FF = 4, FC = 3;
    localparam logic [2:0] BG = 3'b010;

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic [3:0]  game_state = '0;
    logic [11:0] layer_rgb = '0;
    logic [3:0]  layer_dav = '0;
    logic        flash_req = 1'b0;
    logic [2:0]  rgb_out;
    logic        pix_active;
    logic        flash_busy;

    draw_layer_arbiter #(
        .H_VISIBLE(HV), .V_VISIBLE(VV), .BG_RGB(BG),
        .STATE_LOGO(4'b0000), .LOGO_MASK(4'b1101), .PLAY_MASK(4'b0111),
        .BLINK_BIT(5), .FLASH_FRAMES(FF), .FLASH_CYCLES(FC)
    ) dut (
        .vga_clk(vga_clk), .rst(rst), .x(x), .y(y), .game_state(game_state),
        .layer_rgb(layer_rgb), .layer_dav(layer_dav), .flash_req(flash_req),
        .rgb_out(rgb_out), .pix_active(pix_active), .flash_busy(flash_busy)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model: frames counted as completed frame_starts; flash as frame offsets.
    int cx = 0, cy = 0;
    int nstarts = 0;
    bit fs_pend = 0;
    int mode = 0;        // 0 idle, 1 waiting for frame start, 2 running
    int on_start = 0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic [3:0] en;
        logic [2:0] exp_rgb;
        logic [2:0] col;
        logic       exp_act;
        bit         on, found;
        int         mode_pre;
        x = 11'(cx);
        y = 10'(cy);
        exp_rgb = 3'b000;
        exp_act = 1'b0;
        if (!rst && cx < HV && cy < VV) begin
            en = (game_state == 4'b0000) ? 4'b1101 : 4'b0111;
            if (((nstarts % 64) / 32) == 1) en[3] = 1'b0;
            on = (mode == 2) && ((((nstarts - on_start) / FF) % 2) == 0);
            exp_rgb = BG;
            found = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && layer_dav[i] && en[i]) begin
                    found = 1;
                    col = layer_rgb[3*i +: 3];
                    exp_rgb = (i == 1 && on) ? ~col : col;
                    exp_act = 1'b1;
                end
            end
        end
        @(posedge vga_clk);
        #1;
        check("rgb_out", {1'b0, rgb_out}, {1'b0, exp_rgb});
        check("pix_active", {3'b0, pix_active}, {3'b0, exp_act});
        if (rst) begin
            nstarts = 0;
            fs_pend = 0;
            mode = 0;
        end else begin
            mode_pre = mode;
            if (fs_pend) begin
                nstarts++;
                if (mode_pre == 1) begin
                    mode = 2;
                    on_start = nstarts;
                end else if (mode_pre == 2 && nstarts - on_start >= 2 * FF * FC) begin
                    mode = 0;
                end
            end
            if (mode_pre == 0 && flash_req) mode = 1;
            fs_pend = (cx == 0 && cy == 0);
        end
        check("flash_busy", {3'b0, flash_busy}, {3'b0, mode != 0});
        cx++;
        if (cx == HT) begin
            cx = 0;
            cy = (cy + 1) % VT;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset dominates, even with a flash request pending
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            flash_req = 1'(i % 2);
            tick();
        end
        flash_req = 1'b0;
        rst = 1'b0;
        run(2 * FRAME);

        // Priority and mask gating
        game_state = 4'b0001;
        layer_rgb  = {3'b000, 3'b110, 3'b100, 3'b011};
        layer_dav  = 4'b0111;
        run(FRAME);
        layer_dav  = 4'b0110;
        run(FRAME);
        game_state = 4'b0000;
        layer_dav  = 4'b0010;
        run(FRAME);

        // Text blink across a full frame_cnt wrap
        layer_rgb = {3'b111, 3'b110, 3'b100, 3'b011};
        layer_dav = 4'b1000;
        run(66 * FRAME);

        // Board flash, with a request mid-flash that must be ignored
        game_state = 4'b0001;
        layer_dav  = 4'b0010;
        layer_rgb  = {3'b000, 3'b000, 3'b100, 3'b000};
        flash_req = 1'b1; tick(); flash_req = 1'b0;
        run(10 * FRAME + 7);
        flash_req = 1'b1; tick(); flash_req = 1'b0;
        run(20 * FRAME);

        // Reset during the ON phase
        flash_req = 1'b1; tick(); flash_req = 1'b0;
        run(2 * FRAME + 13);
        rst = 1'b1; tick(); rst = 1'b0;
        run(2 * FRAME);

        // Random traffic
        for (int i = 0; i < 60 * FRAME; i++) begin
            layer_rgb = 12'($urandom);
            layer_dav = 4'($urandom);
            if ($urandom_range(0, 49) == 0)
                game_state = ($urandom_range(0, 1) == 0) ? 4'(($urandom_range(0, 1))) : 4'($urandom);
            flash_req = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0;
        flash_req = 1'b0;
        run(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
